// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI serial-clock engine.
package spi_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [1:0] SPI_RUN  = 2'b00;
  localparam logic [1:0] SPI_WAIT = 2'b01;

  // Baud divisor D = (sppr+1) << (spr+1); caller narrows to its divisor width.
  function automatic logic [31:0] calc_divisor(input logic [31:0] sppr_v,
                                               input logic [31:0] spr_v);
    return (sppr_v + 32'd1) << (spr_v + 32'd1);
  endfunction

endpackage

// File: rtl/spi_half_period_cnt.sv
// Half-period counter: holds the latched half-period H and flags cnt==H-1 / cnt==H-2.
module spi_half_period_cnt #(
  parameter int unsigned DIV_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] half_in,
  output logic             term_c,
  output logic             pre_c
);

  logic [DIV_W-1:0] half_q, half_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign term_c = (cnt_q == half_q - DIV_W'(1));
  // With H==1 there is no cycle before the edge, so no pre-terminal.
  assign pre_c  = (half_q > DIV_W'(1)) && (cnt_q == half_q - DIV_W'(2));

  always_comb begin
    half_d = half_q;
    cnt_d  = cnt_q;
    if (load) begin
      half_d = half_in;
      cnt_d  = '0;
    end else if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = term_c ? '0 : cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      half_q <= '0;
      cnt_q  <= '0;
    end else begin
      half_q <= half_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_sclk_engine.sv
// SPI master serial-clock engine: divisor, SCLK generation, framing and
// sample/shift strobes with one-cycle-early pre-strobes.
module spi_sclk_engine
  import spi_pkg::*;
#(
  parameter int unsigned PRE_W  = 3,
  parameter int unsigned SPR_W  = 3,
  parameter int unsigned DIV_W  = 12,
  parameter int unsigned BITS_W = 4
) (
  input  logic              PClk,
  input  logic              PRESET,
  input  logic              SS,
  input  logic              spiswai,
  input  logic [1:0]        spi_mode,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [PRE_W-1:0]  sppr,
  input  logic [SPR_W-1:0]  spr,
  input  logic [BITS_W-1:0] frame_bits,
  input  logic              start,
  output logic              sclk,
  output logic              busy,
  output logic              done,
  output logic              abort,
  output logic              sample_strb,
  output logic              shift_strb,
  output logic              sample_pre,
  output logic              shift_pre,
  output logic [DIV_W-1:0]  baud_rate_divisor,
  output logic [BITS_W:0]   edge_cnt
);

  localparam int unsigned EC_W = BITS_W + 1;
  localparam int unsigned NB_W = BITS_W + 2;

  if (DIV_W < PRE_W + (1 << SPR_W) + 1) begin : g_div_w_check
    $error("spi_sclk_engine: DIV_W too narrow for the largest divisor");
  end

  state_e            state_q, state_d;
  logic              sclk_q, sclk_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              abort_q, abort_d;
  logic              samp_q, samp_d;
  logic              shift_q, shift_d;
  logic              spre_q, spre_d;
  logic              shpre_q, shpre_d;
  logic [EC_W-1:0]   edge_q, edge_d;
  logic [BITS_W-1:0] bits_q, bits_d;

  logic              select_c;
  logic [DIV_W-1:0]  half_c;
  logic [NB_W-1:0]   nbits_c;
  logic [NB_W-1:0]   last_idx_c;
  logic              last_c;
  logic              samp_sel_c;
  logic              cnt_load, cnt_clr, cnt_en;
  logic              term_c, pre_c;

  assign baud_rate_divisor = DIV_W'(calc_divisor(32'(sppr), 32'(spr)));
  assign half_c            = {1'b0, baud_rate_divisor[DIV_W-1:1]};
  assign select_c          = ~SS & ~spiswai & ((spi_mode == SPI_RUN) | (spi_mode == SPI_WAIT));

  // Frame length N (0 encodes 2^BITS_W); the frame ends on edge 2N.
  assign nbits_c    = (bits_q == '0) ? (NB_W'(1) << BITS_W) : NB_W'(bits_q);
  assign last_idx_c = (nbits_c << 1) - NB_W'(1);
  assign last_c     = (edge_q == EC_W'(last_idx_c));

  // Upcoming edge is leading when an even number of edges is done so far.
  assign samp_sel_c = ~edge_q[0] ^ cpha;

  spi_half_period_cnt #(
    .DIV_W (DIV_W)
  ) u_half_cnt (
    .clk     (PClk),
    .rst     (PRESET),
    .load    (cnt_load),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .half_in (half_c),
    .term_c  (term_c),
    .pre_c   (pre_c)
  );

  always_comb begin
    state_d  = state_q;
    sclk_d   = sclk_q;
    busy_d   = busy_q;
    edge_d   = edge_q;
    bits_d   = bits_q;
    done_d   = 1'b0;
    abort_d  = 1'b0;
    samp_d   = 1'b0;
    shift_d  = 1'b0;
    spre_d   = 1'b0;
    shpre_d  = 1'b0;
    cnt_load = 1'b0;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        sclk_d  = cpol;
        edge_d  = '0;
        busy_d  = 1'b0;
        cnt_clr = 1'b1;
        if (start && select_c) begin
          state_d  = RUN;
          busy_d   = 1'b1;
          bits_d   = frame_bits;
          cnt_load = 1'b1;
        end
      end
      RUN: begin
        if (!select_c) begin
          state_d = IDLE;
          sclk_d  = cpol;
          edge_d  = '0;
          busy_d  = 1'b0;
          abort_d = 1'b1;
          cnt_clr = 1'b1;
        end else if (term_c) begin
          sclk_d  = ~sclk_q;
          samp_d  = samp_sel_c;
          shift_d = ~samp_sel_c;
          if (last_c) begin
            done_d = 1'b1;
            edge_d = '0;
            // A start on the final edge chains the next frame with no gap.
            if (start) begin
              bits_d   = frame_bits;
              cnt_load = 1'b1;
            end else begin
              state_d = IDLE;
              busy_d  = 1'b0;
              cnt_clr = 1'b1;
            end
          end else begin
            edge_d = edge_q + EC_W'(1);
            cnt_en = 1'b1;
          end
        end else begin
          cnt_en = 1'b1;
          if (pre_c) begin
            spre_d  = samp_sel_c;
            shpre_d = ~samp_sel_c;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PClk or posedge PRESET) begin
    if (PRESET) begin
      state_q <= IDLE;
      sclk_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      samp_q  <= 1'b0;
      shift_q <= 1'b0;
      spre_q  <= 1'b0;
      shpre_q <= 1'b0;
      edge_q  <= '0;
      bits_q  <= '0;
    end else begin
      state_q <= state_d;
      sclk_q  <= sclk_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      abort_q <= abort_d;
      samp_q  <= samp_d;
      shift_q <= shift_d;
      spre_q  <= spre_d;
      shpre_q <= shpre_d;
      edge_q  <= edge_d;
      bits_q  <= bits_d;
    end
  end

  assign sclk        = sclk_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign abort       = abort_q;
  assign sample_strb = samp_q;
  assign shift_strb  = shift_q;
  assign sample_pre  = spre_q;
  assign shift_pre   = shpre_q;
  assign edge_cnt    = edge_q;

endmodule

// File: tb/tb_spi_sclk_engine.sv
// Bench for spi_sclk_engine: directed and random frames checked against an
// arithmetic timing model of edges, strobes and frame end.
module tb_spi_sclk_engine;

  localparam int unsigned PRE_W  = 3;
  localparam int unsigned SPR_W  = 3;
  localparam int unsigned DIV_W  = 12;
  localparam int unsigned BITS_W = 4;

  logic              PClk = 1'b0;
  logic              PRESET;
  logic              SS;
  logic              spiswai;
  logic [1:0]        spi_mode;
  logic              cpol;
  logic              cpha;
  logic [PRE_W-1:0]  sppr;
  logic [SPR_W-1:0]  spr;
  logic [BITS_W-1:0] frame_bits;
  logic              start;
  logic              sclk, busy, done, abort;
  logic              sample_strb, shift_strb, sample_pre, shift_pre;
  logic [DIV_W-1:0]  baud_rate_divisor;
  logic [BITS_W:0]   edge_cnt;

  int unsigned errors = 0;
  int unsigned checks = 0;

  spi_sclk_engine #(
    .PRE_W (PRE_W), .SPR_W (SPR_W), .DIV_W (DIV_W), .BITS_W (BITS_W)
  ) dut (
    .PClk              (PClk),
    .PRESET            (PRESET),
    .SS                (SS),
    .spiswai           (spiswai),
    .spi_mode          (spi_mode),
    .cpol              (cpol),
    .cpha              (cpha),
    .sppr              (sppr),
    .spr               (spr),
    .frame_bits        (frame_bits),
    .start             (start),
    .sclk              (sclk),
    .busy              (busy),
    .done              (done),
    .abort             (abort),
    .sample_strb       (sample_strb),
    .shift_strb        (shift_strb),
    .sample_pre        (sample_pre),
    .shift_pre         (shift_pre),
    .baud_rate_divisor (baud_rate_divisor),
    .edge_cnt          (edge_cnt)
  );

  always #5 PClk = ~PClk;

  task automatic chk(input string tag, input int t, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0d observed=%0d expected=%0d", tag, t, obs, exp);
    end
  endtask

  function automatic int divisor_of(input int sp, input int sr);
    return (sp + 1) * (2 ** (sr + 1));
  endfunction

  // Model: edges at t = e*H (e = 1..2N); odd edges lead; pre-strobe one cycle earlier.
  task automatic chk_cycle(input int t, input int h, input int n, input bit cp, input bit ch,
                           input bit hold_busy);
    int total, e, up;
    bit on, lead, pre_on, up_lead;
    total   = 2 * n * h;
    e       = t / h;
    on      = (t > 0) && (t % h == 0);
    lead    = (e % 2) == 1;
    up      = (t + 1) / h;
    pre_on  = (h > 1) && ((t + 1) % h == 0) && (t + 1 <= total);
    up_lead = (up % 2) == 1;
    chk("sclk",        t, 32'(sclk),        32'(cp ^ lead));
    chk("sample_strb", t, 32'(sample_strb), 32'(on && (lead != ch)));
    chk("shift_strb",  t, 32'(shift_strb),  32'(on && (lead == ch)));
    chk("sample_pre",  t, 32'(sample_pre),  32'(pre_on && (up_lead != ch)));
    chk("shift_pre",   t, 32'(shift_pre),   32'(pre_on && (up_lead == ch)));
    chk("edge_cnt",    t, 32'(edge_cnt),    (t < total) ? e : 0);
    chk("done",        t, 32'(done),        32'(t == total));
    chk("busy",        t, 32'(busy),        32'((t < total) || hold_busy));
    chk("abort",       t, 32'(abort),       32'd0);
  endtask

  // Runs one frame from the current sample point (#1 after a rising edge).
  task automatic run_frame(input int sp, input int sr, input bit cp, input bit ch, input int fb,
                           input bit chain_in, input bit chain_out, input int abort_at,
                           input int chg_at);
    int h, n, total;
    h     = divisor_of(sp, sr) / 2;
    n     = (fb == 0) ? 16 : fb;
    total = 2 * n * h;
    if (!chain_in) begin
      sppr       = PRE_W'(sp);
      spr        = SPR_W'(sr);
      cpol       = cp;
      cpha       = ch;
      frame_bits = BITS_W'(fb);
      start      = 1'b1;
      @(posedge PClk); #1;
      start = 1'b0;
      chk("baud", 0, 32'(baud_rate_divisor), divisor_of(sp, sr));
      chk_cycle(0, h, n, cp, ch, 1'b0);
    end
    for (int t = 1; t <= total; t++) begin
      if (chain_out && t == total) start = 1'b1;
      @(posedge PClk); #1;
      start = 1'b0;
      if (t == abort_at) begin
        chk("abort_pulse", t, 32'(abort),       32'd1);
        chk("abort_done",  t, 32'(done),        32'd0);
        chk("abort_sclk",  t, 32'(sclk),        32'(cp));
        chk("abort_edge",  t, 32'(edge_cnt),    32'd0);
        chk("abort_busy",  t, 32'(busy),        32'd0);
        chk("abort_strb",  t, 32'(sample_strb | shift_strb), 32'd0);
        SS = 1'b0;
        @(posedge PClk); #1;
        chk("abort_once",  t + 1, 32'(abort), 32'd0);
        chk("abort_idle",  t + 1, 32'(busy),  32'd0);
        break;
      end
      chk_cycle(t, h, n, cp, ch, chain_out);
      if (t == chg_at) begin
        sppr = 3'd7;
        #1;
        chk("baud_live", t, 32'(baud_rate_divisor), divisor_of(7, sr));
      end
      if (abort_at > 0 && t == abort_at - 1) SS = 1'b1;
    end
  endtask

  // A start that must be ignored: no busy, no abort, sclk parked at cpol.
  task automatic chk_ignored(input string tag);
    start = 1'b1;
    @(posedge PClk); #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_busy"},  i, 32'(busy),     32'd0);
      chk({tag, "_abort"}, i, 32'(abort),    32'd0);
      chk({tag, "_sclk"},  i, 32'(sclk),     32'(cpol));
      chk({tag, "_edge"},  i, 32'(edge_cnt), 32'd0);
      @(posedge PClk); #1;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sclk"},  0, 32'(sclk),     32'd0);
    chk({tag, "_busy"},  0, 32'(busy),     32'd0);
    chk({tag, "_done"},  0, 32'(done),     32'd0);
    chk({tag, "_abort"}, 0, 32'(abort),    32'd0);
    chk({tag, "_strb"},  0, 32'({sample_strb, shift_strb, sample_pre, shift_pre}), 32'd0);
    chk({tag, "_edge"},  0, 32'(edge_cnt), 32'd0);
  endtask

  initial begin
    int sp, sr, fb;
    bit cp, ch;
    PRESET     = 1'b1;
    SS         = 1'b0;
    spiswai    = 1'b0;
    spi_mode   = 2'b00;
    cpol       = 1'b1;
    cpha       = 1'b0;
    sppr       = '0;
    spr        = '0;
    frame_bits = '0;
    start      = 1'b0;

    repeat (3) @(posedge PClk);
    #1;
    chk_all_zero("reset");
    PRESET = 1'b0;
    @(posedge PClk); #1;
    chk("post_reset_sclk", 0, 32'(sclk), 32'd1);

    // D=12 mode 0 byte, then D=2 mode 3 sixteen-bit frame.
    run_frame(2, 1, 1'b0, 1'b0, 8, 1'b0, 1'b0, 0, 0);
    run_frame(0, 0, 1'b1, 1'b1, 0, 1'b0, 1'b0, 0, 0);

    // Abort after five edges by raising SS.
    run_frame(2, 1, 1'b0, 1'b0, 8, 1'b0, 1'b0, 31, 0);

    // Divisor change mid-frame; following frame runs at H=16.
    run_frame(2, 1, 1'b0, 1'b0, 8, 1'b0, 1'b0, 0, 20);
    run_frame(7, 1, 1'b0, 1'b0, 8, 1'b0, 1'b0, 0, 0);

    // Back-to-back frames with start on the final edge.
    run_frame(2, 1, 1'b0, 1'b1, 4, 1'b0, 1'b1, 0, 0);
    run_frame(2, 1, 1'b0, 1'b1, 4, 1'b1, 1'b0, 0, 0);

    spiswai = 1'b1;
    chk_ignored("spiswai");
    spiswai = 1'b0;
    spi_mode = 2'b10;
    chk_ignored("stop_mode");
    SS = 1'b1;
    spi_mode = 2'b00;
    chk_ignored("ss_high");
    SS = 1'b0;

    for (int i = 0; i < 6; i++) begin
      sp = int'($urandom_range(0, 7));
      sr = int'($urandom_range(0, 2));
      fb = int'($urandom_range(0, 15));
      cp = 1'($urandom_range(0, 1));
      ch = 1'($urandom_range(0, 1));
      spi_mode = 2'($urandom_range(0, 1));
      run_frame(sp, sr, cp, ch, fb, 1'b0, 1'b0, 0, 0);
    end
    spi_mode = 2'b00;

    // Asynchronous reset mid-frame, between clock edges.
    sppr = 3'd2; spr = 3'd1; cpol = 1'b1; cpha = 1'b0; frame_bits = 4'd8;
    start = 1'b1;
    @(posedge PClk); #1;
    start = 1'b0;
    repeat (20) @(posedge PClk);
    #3;
    PRESET = 1'b1;
    #1;
    chk_all_zero("async_reset");
    @(posedge PClk); #1;
    chk("reset_hold_sclk", 0, 32'(sclk), 32'd0);
    PRESET = 1'b0;
    @(posedge PClk); #1;
    chk("release_sclk", 1, 32'(sclk), 32'd1);
    chk("release_busy", 1, 32'(busy), 32'd0);
    chk("release_done", 1, 32'(done), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_sclk_engine.md
Name: spi_sclk_engine

Overview:
- Parametrised SPI serial-clock engine for the SPI master path. It generalises the fixed 12-bit baud generator.
- Computes the baud divisor from SPPR/SPR and generates SCLK for every CPOL/CPHA mode.
- Runs framed transfers of a programmable bit count using a start/done handshake, and issues sample/shift strobes plus one-cycle-early pre-strobes to the shift register and the control FSM.
- Supports abort on SS deassertion or wait-mode entry.

Parameters:
- PRE_W, 3: width of sppr; prescale factor = sppr+1.
- SPR_W, 3: width of spr; shift factor = 2^(spr+1).
- DIV_W, 12: divisor/counter width. Must hold (2^PRE_W)*2^(2^SPR_W); elaboration error otherwise.
- BITS_W, 4: width of frame_bits. Value 0 encodes 2^BITS_W bits.

Ports:
- PClk  in  1  system clock; all logic on rising edge.
- PRESET  in  1  asynchronous, active-high reset.
- SS  in  1  slave select, active low; 1 = disabled.
- spiswai  in  1  wait-mode stop; 1 = halt.
- spi_mode  in  2  00 run, 01 wait-run, 1x stop.
- cpol  in  1  SCLK idle level.
- cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge.
- sppr  in  PRE_W  prescaler select.
- spr  in  SPR_W  rate select.
- frame_bits  in  BITS_W  bits per frame.
- start  in  1  frame request, one-cycle pulse.
- sclk  out  1  serial clock.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse on normal frame completion.
- abort  out  1  one-cycle pulse when a frame is cut short.
- sample_strb  out  1  pulse coincident with each sample edge.
- shift_strb  out  1  pulse coincident with each shift edge.
- sample_pre  out  1  pulse one PClk before sample_strb.
- shift_pre  out  1  pulse one PClk before shift_strb.
- baud_rate_divisor  out  DIV_W  live divisor D.
- edge_cnt  out  BITS_W+1  number of SCLK edges completed in the current frame.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, latched divisor 0. sclk is 0 during reset; from the first clock after release it follows cpol while IDLE.
- Divisor: D = (sppr+1) << (spr+1), computed combinationally at DIV_W bits with no truncation. Half-period H = D>>1; D is always even.
- SCLK period is D PClk cycles.
- select = ~SS & ~spiswai & (spi_mode==00 | spi_mode==01).
- H is latched when a frame is accepted. Changes to sppr/spr mid-frame do not affect the running frame; baud_rate_divisor output always reflects the live inputs.
- FSM states: IDLE and RUN.
- IDLE:
  - sclk <= cpol; cnt = 0; edge_cnt = 0.
  - start & select at rising edge k: RUN from k, busy=1, cnt=0.
  - start while busy is ignored. start with select=0 is ignored, and no abort is raised.
- RUN, counting:
  - cnt increments each cycle.
  - When cnt==H-1: cnt<=0, sclk<=~sclk, edge_cnt++.
- RUN, strobes:
  - Odd edges (1, 3, ...) are leading edges; even edges are trailing edges.
  - cpha=0: sample_strb on leading edges, shift_strb on trailing edges.
  - cpha=1: the reverse.
  - Strobes are registered and assert in the same cycle as the sclk change.
  - Pre-strobes assert when cnt==H-2, qualified by the type of the upcoming edge. When H==1 the pre-strobes are held 0.
- Frame end:
  - The 2*N-th edge (N = frame_bits, 0 -> 2^BITS_W) asserts done for that cycle and returns the FSM to IDLE.
  - busy drops in the same cycle. sclk is then at the cpol level by parity.
  - Back-to-back: a start on the done cycle is accepted, and the next frame begins with no gap cycle.
- Abort: select falling in RUN gives IDLE next edge with sclk<=cpol, cnt and edge_cnt cleared, abort pulsed, and no done or strobes.
- cpol/cpha changes in RUN are undefined for the data. The FSM keeps toggling and completes the frame normally.
- PRESET mid-frame: immediate return to reset values, with no done or abort.
- Never more than one of sample_strb/shift_strb is high in the same cycle.

Decomposition:
- Package spi_pkg:
  - state enum (IDLE, RUN).
  - function calc_divisor(sppr, spr) parametrised by widths.
  - mode encodings SPI_RUN=2'b00, SPI_WAIT=2'b01.
- Sub-module spi_half_period_cnt:
  - loadable down/up counter with terminal (cnt==H-1) and pre-terminal (cnt==H-2) outputs, plus clear.
  - Instantiated once; the FSM, sclk toggle and strobe decode stay in the top.

Test Plan:
- sppr=2, spr=1 (D=12, H=6), cpol=0, cpha=0, frame_bits=8, start at edge k:
  - sclk rises at k+6; sample_strb at k+6, k+18 ... k+90; shift_strb at k+12 ... k+96.
  - sample_pre at k+5; done and busy-fall at k+96; sclk=0.
- sppr=0, spr=0 (D=2, H=1), cpol=1, cpha=1, frame_bits=0 (16 bits):
  - sclk toggles every cycle starting at k+1; 32 edges; done at k+32.
  - shift_strb on odd edges; pre-strobes stay 0.
- Abort: D=12 frame with SS raised after 5 edges -> abort pulse, no done, sclk=cpol next cycle, edge_cnt=0.
- Mid-frame sppr change 2->7 -> frame still completes at k+96; baud_rate_divisor shows 32 immediately. Next frame uses H=16.
- Back-to-back: start asserted on the done cycle -> busy remains 1, next first edge at done+6. spiswai=1 at start -> ignored, busy stays 0.
- PRESET asserted asynchronously mid-frame -> all outputs 0 without waiting for a clock edge. After release, sclk follows cpol=1 from the next edge.
